// File: rtl/mmm_pkg.sv
// Shared definitions for the MMM input-stream source.
//   tx_state_t      : transfer FSM states
//   MMM_*           : default geometry (M=7, N=9, MAXK=8) and B operand base
//   mmm_b_base()    : B base address (M*MAXK) for arbitrary geometry
//   mmm_tuser_pack(): TUSER word {K, new_A}
package mmm_pkg;

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, DRAIN} tx_state_t;

  localparam int unsigned MMM_M      = 7;
  localparam int unsigned MMM_N      = 9;
  localparam int unsigned MMM_MAXK   = 8;
  localparam int unsigned MMM_B_BASE = MMM_M * MMM_MAXK;

  function automatic int unsigned mmm_b_base(input int unsigned m, input int unsigned maxk);
    return m * maxk;
  endfunction

  // Caller truncates to K_BITS+1.
  function automatic int unsigned mmm_tuser_pack(input int unsigned k, input logic new_a);
    return (k << 1) | {31'd0, new_a};
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// 2-entry valid/ready buffer. The head entry drives the output directly,
// so out_valid_o/out_data_o are registered and independent of out_ready_i.
// The producer must only push when a slot is guaranteed (it uses occ_o).
//   clk_i, rst_ni          : clock, async active-low reset
//   in_valid_i, in_data_i  : push side (no ready; space is pre-reserved)
//   out_valid_o/_ready_i/_data_o : stream side
//   occ_o                  : entries held (0..2)
module axis_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    pop    = (occ_q != 2'd0) && out_ready_i;
    case ({in_valid_i, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = in_data_i;
        else               tail_d = in_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = in_data_i;
        end else begin
          head_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = head_q;
  assign occ_o       = occ_q;

endmodule

// File: rtl/mmm_stream_tx.sv
// AXI-stream source feeding the MMM accelerator input port. Reads A (M x K,
// row-major at 0) and/or B (K x N, row-major at M*MAXK) from a word memory
// with 1-cycle read latency and streams them one word per clock, with
// TUSER = {K, new_A} on every word.
// Ports: clk, reset (async, active-low); start/start_k/start_new_a launch;
// busy, done (pulse), err (pulse on bad K); mem_rd_en/mem_addr/mem_rdata;
// OUTPUT_TDATA/TVALID/TUSER/TREADY.
// Optional: define MMM_TX_LAST_EN to add OUTPUT_TLAST on the final word.
module mmm_stream_tx
  import mmm_pkg::*;
#(
  parameter int unsigned INW    = 12,
  parameter int unsigned M      = MMM_M,
  parameter int unsigned N      = MMM_N,
  parameter int unsigned MAXK   = MMM_MAXK,
  parameter int unsigned K_BITS = $clog2(MAXK + 1),
  parameter int unsigned AW     = $clog2(M * MAXK + MAXK * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [K_BITS-1:0] start_k,
  input  logic              start_new_a,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [INW-1:0]    mem_rdata,
  output logic [INW-1:0]    OUTPUT_TDATA,
  output logic              OUTPUT_TVALID,
  output logic [K_BITS:0]   OUTPUT_TUSER,
  input  logic              OUTPUT_TREADY
`ifdef MMM_TX_LAST_EN
  ,
  output logic              OUTPUT_TLAST
`endif
);

  localparam int unsigned B_BASE    = mmm_b_base(M, MAXK);
  localparam int unsigned PHASE_MAX = ((M > N) ? M : N) * MAXK;
  localparam int unsigned CW        = $clog2(PHASE_MAX + 1);
`ifdef MMM_TX_LAST_EN
  localparam int unsigned W = INW + K_BITS + 2;
`else
  localparam int unsigned W = INW + K_BITS + 1;
`endif

  tx_state_t       state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [K_BITS:0] tuser_q, tuser_d;
  logic            pend_q;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rd_en, pop;
  int unsigned     slots;
  logic [1:0]      occ;
  logic [W-1:0]    buf_in, buf_out;
`ifdef MMM_TX_LAST_EN
  logic            last_rd, pend_last_q;
`endif

  assign pop = OUTPUT_TVALID & OUTPUT_TREADY;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    tuser_d = tuser_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_en   = 1'b0;
`ifdef MMM_TX_LAST_EN
    last_rd = 1'b0;
`endif
    // Slots already claimed once this cycle's pop is accounted for; a read
    // issued now lands two edges later, and this keeps it within 2 entries
    // while still allowing back-to-back reads when the consumer is ready.
    slots = 32'(occ) + 32'(pend_q) - 32'(pop);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_k == '0 || start_k > K_BITS'(MAXK)) begin
            err_d = 1'b1;
          end else begin
            tuser_d = (K_BITS+1)'(mmm_tuser_pack(32'(start_k), start_new_a));
            if (start_new_a) begin
              state_d = SEND_A;
              addr_d  = '0;
              rem_d   = CW'(M * 32'(start_k));
            end else begin
              state_d = SEND_B;
              addr_d  = AW'(B_BASE);
              rem_d   = CW'(32'(start_k) * N);
            end
          end
        end
      end
      SEND_A, SEND_B: begin
        rd_en = (slots < 2);
        if (rd_en) begin
          if (rem_q == CW'(1)) begin
            if (state_q == SEND_A) begin
              state_d = SEND_B;
              addr_d  = AW'(B_BASE);
              rem_d   = CW'(32'(tuser_q[K_BITS:1]) * N);
            end else begin
              state_d = DRAIN;
              addr_d  = '0;
`ifdef MMM_TX_LAST_EN
              last_rd = 1'b1;
`endif
            end
          end else begin
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - CW'(1);
          end
        end
      end
      DRAIN: begin
        if (pop && occ == 2'd1 && !pend_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      tuser_q <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      tuser_q <= tuser_d;
      pend_q  <= rd_en;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef MMM_TX_LAST_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_last_q <= 1'b0;
    else        pend_last_q <= last_rd;
  end
  assign buf_in = {pend_last_q, tuser_q, mem_rdata};
  assign {OUTPUT_TLAST, OUTPUT_TUSER, OUTPUT_TDATA} = buf_out;
`else
  assign buf_in = {tuser_q, mem_rdata};
  assign {OUTPUT_TUSER, OUTPUT_TDATA} = buf_out;
`endif

  axis_skid_buf #(.W(W)) u_buf (
    .clk_i       (clk),
    .rst_ni      (reset),
    .in_valid_i  (pend_q),
    .in_data_i   (buf_in),
    .out_valid_o (OUTPUT_TVALID),
    .out_ready_i (OUTPUT_TREADY),
    .out_data_o  (buf_out),
    .occ_o       (occ)
  );

  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule
